// File: rtl/mem_pkg.sv
// Shared definitions for the store buffer and its forwarding matcher.
//   ACCESS_BYTES : bytes covered by every memory access (one 64-bit word)
//   SB_ADDR_W    : address width of a buffered entry
//   SB_DATA_W    : data width of a buffered entry
//   sb_entry_t   : one buffered store {addr, data}
//   overlap_e    : relation between two accesses (none / exact / partial)
//   overlap_cmp  : classifies two byte addresses as exact, partial or disjoint
package mem_pkg;

  localparam int unsigned ACCESS_BYTES = 8;
  localparam int unsigned SB_ADDR_W    = 64;
  localparam int unsigned SB_DATA_W    = 64;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    OvlNone    = 2'd0,
    OvlExact   = 2'd1,
    OvlPartial = 2'd2
  } overlap_e;

  // Two 8-byte accesses overlap partially when their start addresses differ by 1..7 in either
  // direction. Differences are taken modulo 2^SB_ADDR_W so accesses straddling the top of the
  // address space still compare correctly.
  function automatic overlap_e overlap_cmp(input logic [SB_ADDR_W-1:0] a,
                                           input logic [SB_ADDR_W-1:0] b);
    logic [SB_ADDR_W-1:0] d_ab;
    logic [SB_ADDR_W-1:0] d_ba;
    d_ab = a - b;
    d_ba = b - a;
    if (d_ab == '0) begin
      return OvlExact;
    end
    if ((d_ab < SB_ADDR_W'(ACCESS_BYTES)) || (d_ba < SB_ADDR_W'(ACCESS_BYTES))) begin
      return OvlPartial;
    end
    return OvlNone;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Combinational age-ordered search of the store buffer for a load address.
// The search starts at the youngest entry (tail-1) and stops at the first valid entry that
// either matches exactly or overlaps partially, so a younger exact match shadows any older
// partial overlap, and a younger partial overlap blocks forwarding from an older exact match.
// Ports:
//   entries  : buffered {addr, data} slots, indexed by FIFO slot
//   valid    : per-slot valid bits
//   tail     : next slot to be written (youngest entry is tail-1)
//   addr     : load byte address
//   hit      : youngest relevant entry is an exact match
//   partial  : youngest relevant entry overlaps without matching
//   fwd_data : data of the matching entry when hit, else 0
module sb_match
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      tail,
  input  logic [SB_ADDR_W-1:0]  addr,
  output logic                  hit,
  output logic                  partial,
  output logic [SB_DATA_W-1:0]  fwd_data
);

  logic [PTR_W-1:0] idx;
  logic             found;
  overlap_e         ovl;

  always_comb begin
    hit      = 1'b0;
    partial  = 1'b0;
    fwd_data = '0;
    found    = 1'b0;
    idx      = '0;
    ovl      = OvlNone;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      // Pointer arithmetic wraps modulo DEPTH (a power of two).
      idx = tail - PTR_W'(k);
      if (!found && valid[idx]) begin
        ovl = overlap_cmp(addr, entries[idx].addr);
        if (ovl == OvlExact) begin
          hit      = 1'b1;
          fwd_data = entries[idx].data;
          found    = 1'b1;
        end else if (ovl == OvlPartial) begin
          partial = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM pipeline register and the 64-bit byte-addressed data memory.
// Stores are queued in a circular FIFO and written to memory lazily, in order, whenever the
// memory port is not needed by a load. Loads access memory in the same cycle; an exact address
// match on a buffered store forwards the youngest such store's data, and a partial overlap
// stalls the pipeline while the buffer drains.
// Ports:
//   clk, rst_n       : clock (rising edge) and asynchronous active-low reset
//   req_valid        : pipeline presents a memory operation this cycle
//   req_write        : operation is a store
//   req_read         : operation is a load
//   req_addr         : byte address (may be unaligned)
//   req_wdata        : store data
//   drain_req        : drain on every free cycle (fence / halt)
//   load_data        : load result, combinational
//   stall            : pipeline must hold its MEM-stage request
//   empty            : no buffered stores
//   mem_addr         : data memory address
//   mem_wdata        : data memory write data
//   mem_write        : data memory write strobe, committed on the rising edge
//   mem_read         : data memory read strobe
//   mem_rdata        : data memory combinational read data
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned HIGH_WATER = 3,
  // Entry storage uses the package entry struct, so these must match SB_ADDR_W / SB_DATA_W.
  parameter int unsigned ADDR_W     = SB_ADDR_W,
  parameter int unsigned DATA_W     = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_read,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              drain_req,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] entries_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic              is_load;
  logic              enq;
  logic              drain;
  logic              port_free;
  logic              full;
  logic              hit;
  logic              partial;
  logic [DATA_W-1:0] fwd_data;

  sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries  (entries_q),
    .valid    (valid_q),
    .tail     (tail_q),
    .addr     (req_addr),
    .hit      (hit),
    .partial  (partial),
    .fwd_data (fwd_data)
  );

  assign is_load = req_valid & req_read;
  assign enq     = req_valid & req_write;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

  // partial is only raised when no younger entry matches exactly.
  assign stall     = is_load & partial;
  assign port_free = ~is_load | stall;

  // A full buffer always drains on a store cycle, so an enqueue never finds the FIFO full.
  assign drain = port_free && !empty &&
                 ((count_q >= CNT_W'(HIGH_WATER)) || full || drain_req || !req_valid || stall);

  assign mem_write = drain;
  assign mem_read  = is_load & ~stall;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (drain) begin
      mem_addr  = entries_q[head_q].addr;
      mem_wdata = entries_q[head_q].data;
    end else if (mem_read) begin
      mem_addr = req_addr;
    end
  end

  always_comb begin
    load_data = '0;
    if (mem_read) begin
      load_data = hit ? fwd_data : mem_rdata;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    // Clear before set: when full, head and tail alias and the new store must stay valid.
    if (drain) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    if (enq) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries_q[tail_q].addr <= req_addr;
      entries_q[tail_q].data <= req_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer. Stimulus pushes the expected memory writes and load
// results into queues; a monitor pops and compares whenever the DUT asserts mem_write or
// mem_read. A small byte-addressed memory model sits on the memory port.
module tb_store_buffer;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned HIGH_WATER = 3;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_read, drain_req;
  logic [63:0] req_addr, req_wdata;
  logic [63:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic        stall, empty, mem_write, mem_read;

  logic [7:0]  mem [256];
  logic        mem_clear;

  logic [63:0] exp_load_q [$];
  wr_t         exp_wr_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH      (DEPTH),
    .HIGH_WATER (HIGH_WATER),
    .ADDR_W     (64),
    .DATA_W     (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_read  (req_read),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .drain_req (drain_req),
    .load_data (load_data),
    .stall     (stall),
    .empty     (empty),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  // Little-endian byte memory, 256 bytes, address wraps.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      for (int k = 0; k < 8; k++) mem[mem_addr[7:0] + 8'(k)] <= mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = mem[mem_addr[7:0] + 8'(k)];
  end

  function automatic logic [63:0] rd64(input logic [7:0] a);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[a + 8'(k)];
    return v;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents on the memory port against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write && mem_read) check1("port_conflict_read", mem_read, 1'b0);
      if (mem_write) begin
        if (exp_wr_q.size() == 0) begin
          check1("unexpected_write", mem_write, 1'b0);
        end else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check64("drain_addr", mem_addr, w.addr);
          check64("drain_data", mem_wdata, w.data);
        end
      end
      if (mem_read) begin
        if (exp_load_q.size() == 0) begin
          check1("unexpected_read", mem_read, 1'b0);
        end else begin
          check64("load_addr", mem_addr, req_addr);
          check64("load_data", load_data, exp_load_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic w, input logic r, input logic [63:0] a,
                     input logic [63:0] d, input logic dr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_write = w;
    req_read  = r;
    req_addr  = a;
    req_wdata = d;
    drain_req = dr;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    cyc(1'b1, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic load(input logic [63:0] a);
    cyc(1'b1, 1'b0, 1'b1, a, 64'd0, 1'b0);
  endtask

  task automatic idle(input logic dr);
    cyc(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, dr);
  endtask

  task automatic push_wr(input logic [63:0] a, input logic [63:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr_q.push_back(w);
  endtask

  initial begin
    logic [63:0] dv [5];
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_read  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    drain_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_empty", empty, 1'b1);
    check1("rst_stall", stall, 1'b0);
    check1("rst_mem_write", mem_write, 1'b0);
    check1("rst_mem_read", mem_read, 1'b0);
    check64("rst_load_data", load_data, 64'd0);
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    rst_n     = 1'b1;

    // Store forwarding: memory keeps the old value until the drain
    store(64'd16, 64'h0000_0000_0000_00AA);
    load(64'd16);
    exp_load_q.push_back(64'h0000_0000_0000_00AA);
    @(negedge clk);
    check1("fwd_stall", stall, 1'b0);
    check64("fwd_mem_before_drain", rd64(8'd16), 64'd0);
    idle(1'b0);
    push_wr(64'd16, 64'h0000_0000_0000_00AA);

    // Youngest matching entry wins
    store(64'd8, 64'h11);
    store(64'd8, 64'h22);
    load(64'd8);
    exp_load_q.push_back(64'h22);
    idle(1'b1);
    push_wr(64'd8, 64'h11);
    idle(1'b1);
    push_wr(64'd8, 64'h22);
    idle(1'b0);
    @(negedge clk);
    check64("youngest_mem8", rd64(8'd8), 64'h22);
    check1("youngest_empty", empty, 1'b1);

    // Partial overlap: one stall cycle while addr 0 drains, then the load reads memory
    store(64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    load(64'd4);
    push_wr(64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check1("ovl_stall", stall, 1'b1);
    check1("ovl_mem_read", mem_read, 1'b0);
    check64("ovl_load_data_zero", load_data, 64'd0);
    load(64'd4);
    // bytes 4..7 = FF from the drained store, byte 8 = 22 from the previous test
    exp_load_q.push_back(64'h0000_0022_FFFF_FFFF);
    @(negedge clk);
    check1("ovl_stall_released", stall, 1'b0);

    // Five back-to-back stores: draining starts once count reaches HIGH_WATER
    for (int i = 0; i < 5; i++) dv[i] = 64'h0123_4567_89AB_CD00 + 64'(i);
    for (int i = 0; i < 5; i++) begin
      store(64'(8 * i), dv[i]);
      if (i >= 3) push_wr(64'(8 * (i - 3)), dv[i - 3]);
      @(negedge clk);
      check1("burst_stall", stall, 1'b0);
      check1("burst_mem_write", mem_write, (i >= 3));
    end
    for (int i = 2; i < 5; i++) begin
      idle(1'b0);
      push_wr(64'(8 * i), dv[i]);
    end
    idle(1'b0);
    @(negedge clk);
    check1("burst_empty", empty, 1'b1);
    for (int i = 0; i < 5; i++) check64("burst_mem", rd64(8'(8 * i)), dv[i]);

    // Reset mid-operation drops three buffered stores
    store(64'd64, 64'hDEAD_BEEF_0000_0001);
    store(64'd72, 64'hDEAD_BEEF_0000_0002);
    store(64'd80, 64'hDEAD_BEEF_0000_0003);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    rst_n     = 1'b0;
    #1;
    check1("midrst_empty", empty, 1'b1);
    check1("midrst_mem_write", mem_write, 1'b0);
    check1("midrst_stall", stall, 1'b0);
    check64("midrst_load_data", load_data, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      @(negedge clk);
      check1("postrst_no_write", mem_write, 1'b0);
    end
    check1("postrst_empty", empty, 1'b1);
    for (int i = 0; i < 3; i++) check64("postrst_mem", rd64(8'(64 + 8 * i)), 64'd0);

    // Idle drain ordering: two consecutive writes, oldest first
    store(64'd40, 64'h4040_4040_4040_4040);
    store(64'd48, 64'h4848_4848_4848_4848);
    idle(1'b0);
    push_wr(64'd40, 64'h4040_4040_4040_4040);
    @(negedge clk);
    check1("order_w0", mem_write, 1'b1);
    check64("order_a0", mem_addr, 64'd40);
    idle(1'b0);
    push_wr(64'd48, 64'h4848_4848_4848_4848);
    @(negedge clk);
    check1("order_w1", mem_write, 1'b1);
    check64("order_a1", mem_addr, 64'd48);
    idle(1'b0);
    @(negedge clk);
    check1("order_done_write", mem_write, 1'b0);
    check1("order_empty", empty, 1'b1);

    // Every expected write and load must have been seen
    check64("writes_outstanding", 64'(exp_wr_q.size()), 64'd0);
    check64("loads_outstanding", 64'(exp_load_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the EX/MEM pipeline register and the byte-addressed 64-bit data memory, and owns the memory port.
- Buffers stores in a small FIFO and drains them lazily to memory.
- Loads go to memory in the same cycle. A load whose address exactly matches a buffered store gets that store's data forwarded.
- Raises a pipeline stall only when a load partially overlaps a buffered store.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- HIGH_WATER, 3, occupancy at or above which the buffer drains every free cycle.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; each access covers 8 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline presents a memory operation this cycle.
- req_write  in  1  operation is a store; ignored unless req_valid.
- req_read  in  1  operation is a load; ignored unless req_valid. req_write and req_read are never both 1.
- req_addr  in  ADDR_W  byte address; need not be aligned.
- req_wdata  in  DATA_W  store data.
- drain_req  in  1  force a drain every free cycle (used for fence/halt).
- load_data  out  DATA_W  load result, combinational, same cycle.
- stall  out  1  pipeline must hold its MEM-stage request.
- empty  out  1  buffer has no entries.
- mem_addr  out  ADDR_W  to data memory.
- mem_wdata  out  DATA_W  to data memory.
- mem_write  out  1  to data memory; the write commits on the posedge.
- mem_read  out  1  to data memory.
- mem_rdata  in  DATA_W  from data memory; combinational read.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - head, tail and count go to 0; all entry valid bits clear; buffered stores are discarded.
  - Outputs: stall=0, empty=1, mem_write=0, mem_read=0, load_data=0.
  - Reset in the middle of operation drops pending stores with no memory write.
- Entries: {addr, data}, kept as a circular FIFO. Pointers wrap modulo DEPTH.
- Store enqueue: req_valid & req_write → entry written at tail on the posedge. It is visible to forwarding from the next cycle. A store never stalls.
- Load, no match:
  - mem_read=1 and mem_addr=req_addr in the same cycle.
  - load_data=mem_rdata.
- Load, exact match: if req_addr equals a buffered entry's addr, load_data = data of the youngest matching entry. mem_read is still driven.
- Load, partial overlap:
  - Overlap means (req_addr - e.addr) mod 2^ADDR_W is in 1..7, or (e.addr - req_addr) mod 2^ADDR_W is in 1..7, for any valid entry e.
  - When overlap is detected and no exact match on a younger entry: stall=1, mem_read=0, load_data=0.
  - Draining then proceeds until no overlapping entry remains.
- Port is free when no load is being issued: req_valid=0, or the request is a store, or the load is stalled.
- Drain condition: port free & count>0 & (count≥HIGH_WATER | drain_req | req_valid=0 | stall).
  - On drain: mem_write=1, mem_addr/mem_wdata = head entry; head advances on the posedge.
- Full (count=DEPTH) with an incoming store: the drain condition holds, so head drains and the store enqueues in the same cycle; count is unchanged.
- Same-cycle enqueue and drain: count unchanged. If count was 0, no drain occurs.
- No load issues while mem_write=1: the port is shared, which the free-port rule guarantees.
- empty = (count==0). Stores become memory-visible in FIFO order only.
- Address arithmetic is done at ADDR_W bits with modulo wrap. Memory-side wrap is memory's concern.

Decomposition:
- Shared package mem_pkg:
  - ACCESS_BYTES=8
  - the entry struct {addr, data}
  - an overlap-compare function (exact / partial / none).
- One sub-module, sb_match: purely combinational age-ordered search over entries that outputs hit, partial and fwd_data. It picks the youngest entry, counting backwards from tail-1.
- FIFO control and the drain policy stay in store_buffer.

Test Plan:
- Store forwarding:
  - Stimulus: store 0xAA at addr 16; next cycle load addr 16.
  - Required: load_data=0xAA, stall=0, memory byte 16 still holds its old value until the drain.
- Youngest wins:
  - Stimulus: store 0x11 then 0x22 to addr 8; load addr 8.
  - Required: load_data=0x22. After drain_req, memory addr 8 reads 0x22.
- Partial overlap:
  - Stimulus: store 0xFFFF_FFFF_FFFF_FFFF to addr 0; load addr 4.
  - Required: stall=1 for exactly one cycle while the entry drains (mem_write=1, mem_addr=0); then stall=0 and load_data comes from memory with bytes 4..7 = 0xFF.
- Full with simultaneous drain:
  - Stimulus: 5 back-to-back stores to addrs 0, 8, 16, 24, 32 with DEPTH=4.
  - Required: no stall; the first drain occurs when count reaches 3 (addr 0); empty=1 after the idle cycles; memory holds all 5 values.
- Reset mid-operation:
  - Stimulus: 3 stores buffered, then rst_n pulsed low for half a cycle.
  - Required: empty=1 immediately, no mem_write ever issued, and memory unchanged.
- Idle drain ordering:
  - Stimulus: stores to 40 then 48, then req_valid=0.
  - Required: mem_write on two consecutive cycles with mem_addr 40 then 48.
